pe_col_drain: RTL and testbench

//  Drains accumulator results leaving the bottom PE of one systolic column (o_o of last PE).

---
 rtl/pe_col_drain.sv | 168 ++++++++++++++++
 tb/tb_pe_col_drain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_drain.sv
// Column drain: rescale bottom-PE accumulators to MUL_BW with saturation, queue them, hand off over valid/ready.
// Latency: 2 cycles from acc_vld_i to out_vld_o on an empty FIFO; 1 result/cycle in and out.
// Backpressure: none toward the array; a result arriving at a full FIFO without a pop is dropped and ovf_o sticks.

module pe_col_drain_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LW'(DEPTH));
    assign do_pop   = pop && (level != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end
endmodule

module pe_col_drain #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 9,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     acc_vld_i,
    input  logic [ACC_BW-1:0]        acc_i,
    input  logic                     acc_last_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [MUL_BW-1:0]        out_data_o,
    output logic                     out_last_o,
    output logic                     ovf_o,
    output logic [15:0]              sat_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    typedef struct packed {
        logic              last;
        logic [MUL_BW-1:0] dat;
    } entry_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || INT_BW + FRA_BW > ACC_BW) begin : g_bad_params
        $error("pe_col_drain: illegal parameter set");
    end

    // Clamp bounds expressed at accumulator width so the compare stays signed.
    logic signed [ACC_BW-1:0] max_v;
    logic signed [ACC_BW-1:0] min_v;
    assign max_v = {{(ACC_BW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
    assign min_v = {{(ACC_BW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

    logic signed [ACC_BW-1:0] shifted;
    logic [MUL_BW-1:0]        clamp_dat;
    logic                     clamp_sat;

    always_comb begin
        shifted   = $signed(acc_i) >>> FRA_BW;
        clamp_dat = shifted[MUL_BW-1:0];
        clamp_sat = 1'b0;
        if (shifted > max_v) begin
            clamp_dat = max_v[MUL_BW-1:0];
            clamp_sat = 1'b1;
        end else if (shifted < min_v) begin
            clamp_dat = min_v[MUL_BW-1:0];
            clamp_sat = 1'b1;
        end
    end

    logic              s1_vld;
    logic              s1_sat;
    entry_t            s1_ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_sat <= 1'b0;
            s1_ent <= '0;
        end else if (clr_i) begin
            s1_vld <= 1'b0;
            s1_sat <= 1'b0;
            s1_ent <= '0;
        end else begin
            s1_vld      <= acc_vld_i;
            s1_sat      <= clamp_sat;
            s1_ent.dat  <= clamp_dat;
            s1_ent.last <= acc_last_i;
        end
    end

    entry_t head;
    logic   fifo_full;
    logic   pop;

    assign out_vld_o  = (level_o != '0);
    assign pop        = out_vld_o && out_rdy_i;
    assign out_data_o = head.dat;
    assign out_last_o = head.last;

    pe_col_drain_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_i),
        .push     (s1_vld),
        .push_dat (s1_ent),
        .pop      (pop),
        .head_dat (head),
        .level    (level_o),
        .full     (fifo_full)
    );

    // Saturation is counted at stage 1, so dropped entries are still counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o     <= 1'b0;
            sat_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_o     <= 1'b0;
            sat_cnt_o <= '0;
        end else begin
            if (s1_vld && fifo_full && !pop) ovf_o <= 1'b1;
            if (s1_vld && s1_sat && sat_cnt_o != 16'hFFFF) sat_cnt_o <= sat_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: constant vectors, hand-built corner sequences and a random stream,
// all compared every cycle against a queue-based model of the drain.
module tb_pe_col_drain;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic        acc_vld_i;
    logic [31:0] acc_i;
    logic        acc_last_i;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        ovf_o;
    logic [15:0] sat_cnt_o;
    logic [3:0]  level_o;

    pe_col_drain #(.INT_BW(5), .FRA_BW(9), .MUL_BW(16), .ACC_BW(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_i),
        .acc_vld_i  (acc_vld_i),
        .acc_i      (acc_i),
        .acc_last_i (acc_last_i),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .ovf_o      (ovf_o),
        .sat_cnt_o  (sat_cnt_o),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: value / 2^9 rounded toward minus infinity, then clamped to 16-bit signed.
    function automatic void conv(input logic [31:0] a, output logic [15:0] d, output bit sat);
        longint v = longint'($signed(a));
        longint q = v / 512;
        if (v < 0 && (v % 512) != 0) q = q - 1;
        sat = 1'b0;
        if (q > 32767)       begin q = 32767;  sat = 1'b1; end
        else if (q < -32768) begin q = -32768; sat = 1'b1; end
        d = 16'(q);
    endfunction

    typedef struct { logic [15:0] dat; bit last; } ent_t;
    ent_t        mq[$];
    bit          m_s1_vld;
    ent_t        m_s1;
    bit          m_s1_sat;
    bit          m_ovf;
    int          m_sat;
    logic [15:0] got_dat[$];
    bit          got_last[$];

    task automatic model_reset();
        mq.delete();
        m_s1_vld = 0;
        m_s1_sat = 0;
        m_ovf    = 0;
        m_sat    = 0;
    endtask

    task automatic model_edge(input bit vld, input logic [31:0] acc, input bit last,
                              input bit rdy, input bit clr);
        logic [15:0] d;
        bit          s;
        if (clr) begin
            model_reset();
            return;
        end
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (m_s1_vld) begin
            if (m_s1_sat && m_sat < 65535) m_sat++;
            if (mq.size() < DEPTH) mq.push_back(m_s1);
            else m_ovf = 1;
        end
        conv(acc, d, s);
        m_s1_vld  = vld;
        m_s1.dat  = d;
        m_s1.last = last;
        m_s1_sat  = s;
    endtask

    task automatic compare_model();
        chk("vld", 32'(out_vld_o), 32'(mq.size() != 0));
        chk("level", 32'(level_o), 32'(mq.size()));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("sat_cnt", 32'(sat_cnt_o), 32'(m_sat));
        if (mq.size() != 0) begin
            chk("data", 32'(out_data_o), 32'(mq[0].dat));
            chk("last", 32'(out_last_o), 32'(mq[0].last));
        end
    endtask

    // Drive one cycle of inputs, clock it through DUT and model, then compare.
    task automatic step(input bit vld, input logic [31:0] acc, input bit last,
                        input bit rdy, input bit clr);
        acc_vld_i  = vld;
        acc_i      = acc;
        acc_last_i = last;
        out_rdy_i  = rdy;
        clr_i      = clr;
        if (out_vld_o && rdy && !clr) begin
            got_dat.push_back(out_data_o);
            got_last.push_back(out_last_o);
        end
        @(posedge clk);
        model_edge(vld, acc, last, rdy, clr);
        #1;
        compare_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 32'(out_vld_o), 0);
        chk({tag, "_data"}, 32'(out_data_o), 0);
        chk({tag, "_last"}, 32'(out_last_o), 0);
        chk({tag, "_ovf"}, 32'(ovf_o), 0);
        chk({tag, "_sat"}, 32'(sat_cnt_o), 0);
        chk({tag, "_level"}, 32'(level_o), 0);
    endtask

    typedef struct { logic [31:0] acc; logic [15:0] exp_dat; int exp_sat; } vec_t;
    vec_t tbl[10];

    initial begin
        logic [31:0] sent[$];
        int          cyc;
        bit          v;
        logic [15:0] d;
        bit          s;

        tbl[0] = '{32'h0000_0600, 16'h0003, 0};
        tbl[1] = '{32'h7FFF_FFFF, 16'h7FFF, 1};
        tbl[2] = '{32'h8000_0000, 16'h8000, 2};
        tbl[3] = '{32'hFFFF_FE00, 16'hFFFF, 2};
        tbl[4] = '{32'h00FF_FE00, 16'h7FFF, 2};
        tbl[5] = '{32'h0100_0000, 16'h7FFF, 3};
        tbl[6] = '{32'hFF00_0000, 16'h8000, 3};
        tbl[7] = '{32'hFEFF_FFFF, 16'h8000, 4};
        tbl[8] = '{32'hFFFF_FFFF, 16'hFFFF, 4};
        tbl[9] = '{32'h0000_01FF, 16'h0000, 4};

        rst_n = 1'b0; clr_i = 0; acc_vld_i = 0; acc_i = '0; acc_last_i = 0; out_rdy_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Conversion vectors: latency of two edges, one-cycle-wide valid with ready held high.
        foreach (tbl[i]) begin
            step(1, tbl[i].acc, 0, 1, 0);
            chk("lat_vld_t1", 32'(out_vld_o), 0);
            step(0, '0, 0, 1, 0);
            chk("lat_vld_t2", 32'(out_vld_o), 1);
            chk("vec_data", 32'(out_data_o), 32'(tbl[i].exp_dat));
            chk("vec_sat", 32'(sat_cnt_o), 32'(tbl[i].exp_sat));
            step(0, '0, 0, 1, 0);
            chk("one_wide", 32'(out_vld_o), 0);
        end

        // Fill to 8, ninth lost, then drain in order.
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 32'((i + 1) << 9), 0, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("full_level", 32'(level_o), 8);
        chk("full_ovf", 32'(ovf_o), 0);
        step(1, 32'(9 << 9), 0, 0, 0);
        chk("ninth_s1_ovf", 32'(ovf_o), 0);
        step(0, '0, 0, 0, 0);
        chk("drop_ovf", 32'(ovf_o), 1);
        chk("drop_level", 32'(level_o), 8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(out_data_o), 32'(i + 1));
            step(0, '0, 0, 1, 0);
        end
        chk("drain_level", 32'(level_o), 0);

        // Clear with 3 queued, one in stage 1 and ovf still set.
        for (int i = 0; i < 3; i++) step(1, 32'(i << 12), 0, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("clr_pre_level", 32'(level_o), 3);
        chk("clr_pre_ovf", 32'(ovf_o), 1);
        step(1, 32'h0000_4000, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        chk("clr_level", 32'(level_o), 0);
        chk("clr_ovf", 32'(ovf_o), 0);
        step(0, '0, 0, 0, 0);
        chk("clr_drops_s1", 32'(level_o), 0);

        // Full FIFO with a same-cycle pop accepts the ninth.
        for (int i = 0; i < 8; i++) step(1, 32'((i + 1) << 9), 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(1, 32'(9 << 9), 0, 0, 0);
        step(0, '0, 0, 1, 0);
        chk("pp_level", 32'(level_o), 8);
        chk("pp_ovf", 32'(ovf_o), 0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_data", 32'(out_data_o), 32'(i + 2));
            step(0, '0, 0, 1, 0);
        end

        // Random 20-result stream with random ready; last on the final one.
        got_dat.delete();
        got_last.delete();
        cyc = 0;
        while (sent.size() < 20 && cyc < 500) begin
            v = (mq.size() < 6) && ($urandom_range(0, 2) != 0);
            acc_i = $urandom;
            d = 16'($urandom_range(0, 16));
            if (v) sent.push_back(32'($signed($urandom) >>> d));
            step(v, v ? sent[sent.size() - 1] : 32'h0, v && sent.size() == 20,
                 $urandom_range(0, 3) != 0, 0);
            cyc++;
        end
        cyc = 0;
        while (got_dat.size() < 20 && cyc < 100) begin
            step(0, '0, 0, $urandom_range(0, 1) != 0, 0);
            cyc++;
        end
        chk("stream_count", 32'(got_dat.size()), 20);
        foreach (got_dat[i]) begin
            if (i < sent.size()) begin
                conv(sent[i], d, s);
                chk("stream_data", 32'(got_dat[i]), 32'(d));
            end
            chk("stream_last", 32'(got_last[i]), 32'(i == 19));
        end

        // Async reset between edges, mid-stream.
        for (int i = 0; i < 4; i++) step(1, 32'h7FFF_FFFF, 0, 0, 0);
        chk("pre_rst_level", 32'(level_o), 3);
        acc_vld_i = 0;
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, '0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
